// File: rtl/gray_fifo_ptr_ctrl.sv
// Single-clock FIFO pointer controller using Gray-coded read/write pointers.
// Gates write/read requests against full/empty, drives the address and enable
// pins of an external 2^ADDR_W-entry RAM, and exports the Gray pointers so a
// later dual-clock FIFO can reuse them unchanged.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   wr_req     write request for this cycle
//   rd_req     read request for this cycle
//   mem_we     RAM write enable  (wr_req & ~full, combinational)
//   mem_waddr  RAM write address (low bits of binary write pointer)
//   mem_re     RAM read enable   (rd_req & ~empty, combinational)
//   mem_raddr  RAM read address  (low bits of binary read pointer)
//   wr_gray    registered Gray write pointer, ADDR_W+1 bits
//   rd_gray    registered Gray read pointer,  ADDR_W+1 bits
//   full       FIFO holds 2^ADDR_W entries
//   empty      FIFO holds 0 entries
//   count      occupancy, 0 .. 2^ADDR_W
//   overflow   sticky: write requested while full
//   underflow  sticky: read requested while empty
module gray_fifo_ptr_ctrl #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic              rd_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W:0]   wr_gray,
    output logic [ADDR_W:0]   rd_gray,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    // Top two Gray bits differ between pointers exactly one lap apart.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

    logic [PTR_W-1:0] r_wr_bin;
    logic [PTR_W-1:0] r_rd_bin;
    logic [PTR_W-1:0] r_wr_gray;
    logic [PTR_W-1:0] r_rd_gray;
    logic             r_overflow;
    logic             r_underflow;

    logic [PTR_W-1:0] w_wr_bin_nxt;
    logic [PTR_W-1:0] w_rd_bin_nxt;
    logic             w_full;
    logic             w_empty;
    logic             w_we;
    logic             w_re;

    // Flags come from the registered Gray pointers only.
    assign w_empty = (r_wr_gray == r_rd_gray);
    assign w_full  = (r_wr_gray == (r_rd_gray ^ FULL_MASK));

    // Request gating against current-cycle flags.
    assign w_we = wr_req & ~w_full;
    assign w_re = rd_req & ~w_empty;

    assign w_wr_bin_nxt = r_wr_bin + PTR_W'(1);
    assign w_rd_bin_nxt = r_rd_bin + PTR_W'(1);

    // Pointer and sticky-flag state; Gray is encoded from the next binary value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_bin    <= '0;
            r_rd_bin    <= '0;
            r_wr_gray   <= '0;
            r_rd_gray   <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_we) begin
                r_wr_bin  <= w_wr_bin_nxt;
                r_wr_gray <= w_wr_bin_nxt ^ (w_wr_bin_nxt >> 1);
            end
            if (w_re) begin
                r_rd_bin  <= w_rd_bin_nxt;
                r_rd_gray <= w_rd_bin_nxt ^ (w_rd_bin_nxt >> 1);
            end
            if (wr_req & w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_req & w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign mem_we    = w_we;
    assign mem_re    = w_re;
    assign mem_waddr = r_wr_bin[ADDR_W-1:0];
    assign mem_raddr = r_rd_bin[ADDR_W-1:0];
    assign wr_gray   = r_wr_gray;
    assign rd_gray   = r_rd_gray;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_wr_bin - r_rd_bin;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_gray_fifo_ptr_ctrl.sv
// Self-checking bench for gray_fifo_ptr_ctrl: directed scenarios followed by
// random traffic, all checked against an occupancy-level reference model.
module tb_gray_fifo_ptr_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam int          LAP    = 2 * DEPTH;

    logic              clk;
    logic              reset;
    logic              wr_req;
    logic              rd_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [ADDR_W:0]   wr_gray;
    logic [ADDR_W:0]   rd_gray;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    gray_fifo_ptr_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (wr_req),
        .rd_req    (rd_req),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_re    (mem_re),
        .mem_raddr (mem_raddr),
        .wr_gray   (wr_gray),
        .rd_gray   (rd_gray),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: total accepted writes/reads modulo one double lap.
    int m_wr  = 0;
    int m_rd  = 0;
    bit m_ovf = 0;
    bit m_unf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int occ();
        return (m_wr - m_rd + LAP) % LAP;
    endfunction

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // One cycle: drive, check combinational and registered outputs, advance model.
    task automatic step(input bit wr, input bit rd, input bit rst);
        bit exp_full;
        bit exp_empty;
        bit exp_we;
        bit exp_re;
        @(negedge clk);
        wr_req = wr;
        rd_req = rd;
        reset  = rst;
        #1;
        exp_full  = (occ() == DEPTH);
        exp_empty = (occ() == 0);
        exp_we    = wr && !exp_full;
        exp_re    = rd && !exp_empty;
        chk("mem_we",    32'(mem_we),    32'(exp_we));
        chk("mem_re",    32'(mem_re),    32'(exp_re));
        chk("mem_waddr", 32'(mem_waddr), 32'(m_wr % DEPTH));
        chk("mem_raddr", 32'(mem_raddr), 32'(m_rd % DEPTH));
        chk("wr_gray",   32'(wr_gray),   32'(to_gray(m_wr)));
        chk("rd_gray",   32'(rd_gray),   32'(to_gray(m_rd)));
        chk("full",      32'(full),      32'(exp_full));
        chk("empty",     32'(empty),     32'(exp_empty));
        chk("count",     32'(count),     32'(occ()));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        @(posedge clk);
        if (rst) begin
            m_wr  = 0;
            m_rd  = 0;
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (exp_we) m_wr = (m_wr + 1) % LAP;
            if (exp_re) m_rd = (m_rd + 1) % LAP;
            if (wr && exp_full)  m_ovf = 1;
            if (rd && exp_empty) m_unf = 1;
        end
    endtask

    logic [ADDR_W:0] prev_gray;

    initial begin
        reset  = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        @(posedge clk);

        // Reset state, request-free.
        step(0, 0, 0);

        // Fill to full, confirming single-bit Gray steps.
        for (int i = 0; i < DEPTH; i++) begin
            prev_gray = wr_gray;
            step(1, 0, 0);
            #1;
            chk("wr_gray_1bit", 32'($countones(wr_gray ^ prev_gray)), 32'd1);
        end
        #1;
        chk("fill_gray", 32'(wr_gray), 32'b11000);
        chk("fill_full", 32'(full), 32'd1);

        // Overflow attempt, then sticky for ten idle cycles.
        step(1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Simultaneous at full: read only.
        step(1, 1, 0);
        #1;
        chk("simul_full_count", 32'(count), 32'(DEPTH - 1));

        // Drain, then one rejected read.
        for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 0);
        #1;
        chk("drain_eq", 32'(rd_gray), 32'(wr_gray));
        step(0, 1, 0);
        #1;
        chk("unf_set", 32'(underflow), 32'd1);

        // Simultaneous at empty: write only.
        step(1, 1, 0);
        #1;
        chk("simul_empty_count", 32'(count), 32'd1);

        // Wrap-around from reset: 40 write/read pairs.
        step(0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0);
            step(0, 1, 0);
        end
        #1;
        chk("wrap_gray", 32'(wr_gray), 32'b01100);

        // Mid-operation reset with count=9, overflow=1, write asserted.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < DEPTH - 9; i++) step(0, 1, 0);
        #1;
        chk("pre_rst_count", 32'(count), 32'd9);
        step(1, 0, 1);
        step(0, 0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 79) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
